fifo_sync: RTL

//  Single-clock FIFO; parametrised successor of the dual-port FIFO family.

---
 rtl/fifo_sync.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO of arbitrary depth with fill count, almost-full/empty
// thresholds, sticky overflow/underflow errors and optional FWFT read port.
module fifo_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter bit FWFT          = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  wr_en,
  input  logic                                  rd_en,
  input  logic                                  clear_err,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  rd_valid,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       count,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int ADDR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AF_CNT    = COUNT_WIDTH'(AFULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] AE_CNT    = COUNT_WIDTH'(AEMPTY_THRESH);

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    if (ptr == LAST_ADDR) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return ptr + ADDR_WIDTH'(1);
    end
  endfunction

  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   full_q, empty_q, afull_q, aempty_q;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   wr_acc_s, rd_acc_s;

  // Acceptance uses registered flags only; reset suppresses every request.
  always_comb begin
    wr_acc_s   = reset & wr_en & ~full_q;
    rd_acc_s   = reset & rd_en & ~empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc_s) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d   = next_ptr(rd_ptr_q);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (wr_en & full_q)  | (ovf_q & ~clear_err);
    unf_d = (rd_en & empty_q) | (unf_q & ~clear_err);
  end

  // Pointers, occupancy, flags, error bits and the registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q   <= {ADDR_WIDTH{1'b0}};
      count_q    <= {COUNT_WIDTH{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_CNT);
      empty_q    <= (count_d == {COUNT_WIDTH{1'b0}});
      afull_q    <= (count_d >= AF_CNT);
      aempty_q   <= (count_d <= AE_CNT);
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = empty_q ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
